// File: rtl/vec_issue_ctrl_pkg.sv
// Shared pipeline definitions: issue FSM encoding (also decoded by the
// ID/EXE register) and the default element counter width.
package vec_issue_ctrl_pkg;

    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VEC   = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } issue_state_e;

endpackage

// File: rtl/vec_issue_ctrl_if.sv
// ID-stage issue bundle: decoded instruction and EXE feedback in,
// pipeline enables/flushes and issue tags out.
interface vec_issue_ctrl_if #(
    parameter int unsigned CNT_W = vec_issue_ctrl_pkg::CNT_W
);

    logic             id_valid;
    logic             id_is_vec;
    logic [4:0]       id_rs_addr;
    logic [4:0]       id_rt_addr;
    logic             exe_memtoreg;
    logic [4:0]       exe_rt_addr;
    logic             exe_branch_taken;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idexe_flush;
    logic [1:0]       issue_state;
    logic [CNT_W-1:0] issue_cnt;
    logic             vec_done;
    logic             vec_abort;
    logic [15:0]      stall_cycles;

    // Pipeline side: presents ID/EXE status, consumes controls.
    modport master (
        output id_valid, id_is_vec, id_rs_addr, id_rt_addr,
               exe_memtoreg, exe_rt_addr, exe_branch_taken,
        input  pc_en, ifid_en, ifid_flush, idexe_flush,
               issue_state, issue_cnt, vec_done, vec_abort, stall_cycles
    );

    // Controller side.
    modport slave (
        input  id_valid, id_is_vec, id_rs_addr, id_rt_addr,
               exe_memtoreg, exe_rt_addr, exe_branch_taken,
        output pc_en, ifid_en, ifid_flush, idexe_flush,
               issue_state, issue_cnt, vec_done, vec_abort, stall_cycles
    );

endinterface

// File: rtl/vec_issue_ctrl_load_use_detect.sv
// Load-use hazard: ID reads a register that the load now in EXE will write.
// r0 is hard-wired zero and never creates a dependency.
module load_use_detect (
    input  logic       id_valid,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       exe_memtoreg,
    input  logic [4:0] exe_rt_addr,
    output logic       hazard
);

    // Register compare against the EXE load destination.
    always_comb begin
        hazard = id_valid && exe_memtoreg && (exe_rt_addr != 5'd0) &&
                 ((exe_rt_addr == id_rs_addr) || (exe_rt_addr == id_rt_addr));
    end

endmodule

// File: rtl/vec_issue_ctrl.sv
// ID-stage issue controller: branch flush, load-use stall and multi-element
// vector sequencing (instruction held in ID while one element issues per cycle).
module vec_issue_ctrl #(
    parameter int unsigned VLEN  = 16,
    parameter int unsigned CNT_W = vec_issue_ctrl_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    vec_issue_ctrl_if.slave ifc
);

    import vec_issue_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(VLEN - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    issue_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      stall_q;
    // High from reset until the first clock edge: outputs sit at their
    // reset values even after rst_n releases, since they are combinational.
    logic             boot_q;
    logic             hazard;

    logic pc_en, ifid_en, ifid_flush, idexe_flush, vec_done, vec_abort;

    load_use_detect u_load_use_detect (
        .id_valid     (ifc.id_valid),
        .id_rs_addr   (ifc.id_rs_addr),
        .id_rt_addr   (ifc.id_rt_addr),
        .exe_memtoreg (ifc.exe_memtoreg),
        .exe_rt_addr  (ifc.exe_rt_addr),
        .hazard       (hazard)
    );

    // State, element counter and post-reset hold flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            boot_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            boot_q  <= 1'b0;
        end
    end

    // Saturating count of cycles in which the PC is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!boot_q && !pc_en && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    // Next state and pipeline controls; branch > hazard > vector accept.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idexe_flush = 1'b0;
        vec_done    = 1'b0;
        vec_abort   = 1'b0;

        if (boot_q) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            state_d     = ST_IDLE;
            cnt_d       = '0;
        end else if (ifc.exe_branch_taken) begin
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
            vec_abort   = (state_q == ST_VEC);
            state_d     = ST_FLUSH;
            cnt_d       = '0;
        end else begin
            unique case (state_q)
                ST_FLUSH: begin
                    idexe_flush = 1'b1;
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                end
                ST_VEC: begin
                    if (cnt_q == LAST_ELEM) begin
                        vec_done = 1'b1;
                        state_d  = ST_IDLE;
                        cnt_d    = '0;
                    end else begin
                        pc_en   = 1'b0;
                        ifid_en = 1'b0;
                        cnt_d   = cnt_q + ONE;
                    end
                end
                default: begin
                    // STALL is IDLE with the hazard check masked, so the
                    // re-examined instruction cannot stall twice.
                    state_d = ST_IDLE;
                    if ((state_q == ST_IDLE) && hazard) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idexe_flush = 1'b1;
                        state_d     = ST_STALL;
                    end else if (ifc.id_valid && ifc.id_is_vec) begin
                        if (VLEN > 1) begin
                            pc_en   = 1'b0;
                            ifid_en = 1'b0;
                            state_d = ST_VEC;
                            cnt_d   = ONE;
                        end else begin
                            vec_done = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Drive the interface.
    always_comb begin
        ifc.pc_en        = pc_en;
        ifc.ifid_en      = ifid_en;
        ifc.ifid_flush   = ifid_flush;
        ifc.idexe_flush  = idexe_flush;
        ifc.vec_done     = vec_done;
        ifc.vec_abort    = vec_abort;
        ifc.issue_state  = state_q;
        ifc.issue_cnt    = cnt_q;
        ifc.stall_cycles = stall_q;
    end

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Bench for vec_issue_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the issue rules.
module tb_vec_issue_ctrl;

    localparam int unsigned VLEN  = 16;
    localparam int unsigned CNT_W = 5;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    vec_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

    vec_issue_ctrl #(.VLEN(VLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: what the ID stage is doing, in plain terms.
    bit m_boot;       // reset released but no edge seen yet
    bit m_in_vec;     // a vector op is still issuing elements
    int m_elem;       // element issuing this cycle while in_vec
    bit m_flush;      // cycle after a taken branch
    bit m_stalled;    // cycle after a load-use bubble
    int m_stalls;     // held-PC cycles so far

    bit nx_in_vec, nx_flush, nx_stalled;
    int nx_elem, nx_stalls;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit vec, input int rs, input int rt,
                         input bit mr, input int ert, input bit br);
        bus.id_valid         = v;
        bus.id_is_vec        = vec;
        bus.id_rs_addr       = 5'(rs);
        bus.id_rt_addr       = 5'(rt);
        bus.exe_memtoreg     = mr;
        bus.exe_rt_addr      = 5'(ert);
        bus.exe_branch_taken = br;
    endtask

    task automatic model_reset();
        m_boot    = 1'b1;
        m_in_vec  = 1'b0;
        m_elem    = 0;
        m_flush   = 1'b0;
        m_stalled = 1'b0;
        m_stalls  = 0;
    endtask

    // Evaluate expected outputs for the current inputs and compare.
    task automatic check_cycle();
        bit pc, ie, ff, xf, done, abort, hz;
        int st, cn;
        pc = 1; ie = 1; ff = 0; xf = 0; done = 0; abort = 0;
        st = m_flush ? 3 : (m_in_vec ? 1 : (m_stalled ? 2 : 0));
        cn = m_in_vec ? m_elem : 0;
        nx_in_vec  = m_in_vec;
        nx_elem    = m_elem;
        nx_flush   = 0;
        nx_stalled = 0;

        if (m_boot) begin
            pc = 0; ie = 0; ff = 1; xf = 1;
        end else if (bus.exe_branch_taken) begin
            ff = 1; xf = 1; abort = m_in_vec;
            nx_in_vec = 0; nx_elem = 0; nx_flush = 1;
        end else if (m_flush) begin
            xf = 1;
        end else if (m_in_vec) begin
            if (m_elem == VLEN - 1) begin
                done = 1; nx_in_vec = 0; nx_elem = 0;
            end else begin
                pc = 0; ie = 0; nx_elem = m_elem + 1;
            end
        end else begin
            hz = !m_stalled && bus.id_valid && bus.exe_memtoreg && (bus.exe_rt_addr != 0) &&
                 (bus.exe_rt_addr == bus.id_rs_addr || bus.exe_rt_addr == bus.id_rt_addr);
            if (hz) begin
                pc = 0; ie = 0; xf = 1; nx_stalled = 1;
            end else if (bus.id_valid && bus.id_is_vec) begin
                if (VLEN > 1) begin
                    pc = 0; ie = 0; nx_in_vec = 1; nx_elem = 1;
                end else begin
                    done = 1;
                end
            end
        end
        nx_stalls = (!m_boot && !pc && m_stalls < 65535) ? m_stalls + 1 : m_stalls;

        chk("pc_en",        32'(bus.pc_en),        32'(pc));
        chk("ifid_en",      32'(bus.ifid_en),      32'(ie));
        chk("ifid_flush",   32'(bus.ifid_flush),   32'(ff));
        chk("idexe_flush",  32'(bus.idexe_flush),  32'(xf));
        chk("vec_done",     32'(bus.vec_done),     32'(done));
        chk("vec_abort",    32'(bus.vec_abort),    32'(abort));
        chk("issue_state",  32'(bus.issue_state),  32'(st));
        chk("issue_cnt",    32'(bus.issue_cnt),    32'(cn));
        chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stalls));
    endtask

    // One clock: check at the falling edge, advance the model after the rising edge.
    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        m_boot    = 1'b0;
        m_in_vec  = nx_in_vec;
        m_elem    = nx_elem;
        m_flush   = nx_flush;
        m_stalled = nx_stalled;
        m_stalls  = nx_stalls;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        do_reset();

        // Reset values held until the first edge, then a scalar instruction.
        drive(1, 0, 1, 2, 0, 0, 0);
        step();
        step();

        // Load-use: EXE load to r5, ID reads r5.
        drive(1, 0, 5, 7, 1, 5, 0);
        step();
        drive(1, 0, 5, 7, 0, 0, 0);
        step();
        step();
        chk("stall_after_hazard", 32'(bus.stall_cycles), 32'd1);

        // Full vector op.
        drive(1, 1, 1, 2, 0, 0, 0);
        step();
        drive(1, 0, 3, 4, 0, 0, 0);
        repeat (VLEN) step();

        // Branch kills a vector op at element 7.
        drive(1, 1, 1, 2, 0, 0, 0);
        step();
        drive(1, 0, 3, 4, 0, 0, 0);
        repeat (6) step();
        chk("cnt_before_branch", 32'(bus.issue_cnt), 32'd7);
        drive(1, 0, 3, 4, 0, 0, 1);
        step();
        drive(1, 0, 3, 4, 0, 0, 0);
        step();
        step();

        // Hazard and branch together.
        drive(1, 0, 9, 9, 1, 9, 1);
        step();
        drive(1, 0, 1, 2, 0, 0, 0);
        step();
        step();

        // Asynchronous reset in the middle of a vector op.
        drive(1, 1, 1, 2, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        @(negedge clk);
        chk("cnt_before_reset", 32'(bus.issue_cnt), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("rst_issue_cnt",   32'(bus.issue_cnt),   32'd0);
        chk("rst_issue_state", 32'(bus.issue_state), 32'd0);
        chk("rst_vec_done",    32'(bus.vec_done),    32'd0);
        chk("rst_vec_abort",   32'(bus.vec_abort),   32'd0);
        chk("rst_pc_en",       32'(bus.pc_en),       32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Random traffic; small register range so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  $urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
